// File: rtl/pixel_fifo.sv
// Single-clock show-ahead pixel FIFO between the framebuffer reader and the VGA stage.
// All flags derive from one registered level counter; rdata is the head entry, read asynchronously.
module pixel_fifo #(
  parameter int unsigned DATA_WIDTH   = 24,
  parameter int unsigned DEPTH_LOG2   = 8,
  parameter int unsigned AFULL_LEVEL  = (2 ** DEPTH_LOG2) - 16,
  parameter int unsigned AEMPTY_LEVEL = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  write,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  read,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned LvlW  = DEPTH_LOG2 + 1;

  localparam logic [LvlW-1:0]       FullLvl   = LvlW'(Depth);
  localparam logic [LvlW-1:0]       AfullLvl  = LvlW'(AFULL_LEVEL);
  localparam logic [LvlW-1:0]       AemptyLvl = LvlW'(AEMPTY_LEVEL);
  localparam logic [LvlW-1:0]       LvlOne    = LvlW'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne    = DEPTH_LOG2'(1);

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [LvlW-1:0]       level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;

  // Flags come only from the registered level, so no request-to-flag combinational path exists.
  always_comb begin
    wfull         = (level_q == FullLvl);
    rempty        = (level_q == '0);
    walmost_full  = (level_q >= AfullLvl);
    ralmost_empty = (level_q <= AemptyLvl);
    level         = level_q;
    overflow      = overflow_q;
    underflow     = underflow_q;
    rdata         = mem_q[rptr_q];
  end

  always_comb begin
    wr_acc      = write & ~wfull;
    rd_acc      = read & ~rempty;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PtrOne;
      if (rd_acc) rptr_d = rptr_q + PtrOne;
      unique case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LvlOne;
        2'b01:   level_d = level_q - LvlOne;
        default: level_d = level_q;
      endcase
      overflow_d  = overflow_q | (write & wfull);
      underflow_d = underflow_q | (read & rempty);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is neither reset nor flushed; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: tb/tb_pixel_fifo.sv
// Directed bench for pixel_fifo: fill/drain, sustained read+write, flush and async reset.
module tb_pixel_fifo;

  localparam int unsigned DW    = 24;
  localparam int unsigned DL    = 8;
  localparam int unsigned DEPTH = 256;

  logic          clk;
  logic          nrst;
  logic          flush;
  logic [DW-1:0] wdata;
  logic          write;
  logic          wfull;
  logic          walmost_full;
  logic [DW-1:0] rdata;
  logic          read;
  logic          rempty;
  logic          ralmost_empty;
  logic [DL:0]   level;
  logic          overflow;
  logic          underflow;

  int unsigned tests_run;
  int unsigned tests_failed;

  logic [DW-1:0] model_q[$];
  int unsigned   next_val;
  logic          ovf_m;
  logic          unf_m;

  pixel_fifo dut (
    .clk          (clk),
    .nrst         (nrst),
    .flush        (flush),
    .wdata        (wdata),
    .write        (write),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .rdata        (rdata),
    .read         (read),
    .rempty       (rempty),
    .ralmost_empty(ralmost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag);
    int unsigned n;
    n = model_q.size();
    chk({tag, ".level"}, 32'(level), n);
    chk({tag, ".wfull"}, 32'(wfull), 32'(n == DEPTH));
    chk({tag, ".rempty"}, 32'(rempty), 32'(n == 0));
    chk({tag, ".walmost_full"}, 32'(walmost_full), 32'(n >= DEPTH - 16));
    chk({tag, ".ralmost_empty"}, 32'(ralmost_empty), 32'(n <= 16));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ovf_m));
    chk({tag, ".underflow"}, 32'(underflow), 32'(unf_m));
  endtask

  // One clock with the given requests; model acceptance is decided from the pre-edge model size.
  task automatic cycle(input string tag, input bit w, input bit r, input bit f);
    bit wacc, racc;
    write = w;
    read  = r;
    flush = f;
    wdata = DW'(next_val);
    if (model_q.size() > 0) chk({tag, ".rdata"}, 32'(rdata), 32'(model_q[0]));
    wacc = w && (model_q.size() < DEPTH);
    racc = r && (model_q.size() > 0);
    step();
    if (f) begin
      model_q.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      if (w && !wacc) ovf_m = 1'b1;
      if (r && !racc) unf_m = 1'b1;
      if (racc) void'(model_q.pop_front());
      if (wacc) begin
        model_q.push_back(DW'(next_val));
        next_val++;
      end
    end
    write = 1'b0;
    read  = 1'b0;
    flush = 1'b0;
    chk_flags(tag);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    next_val     = 0;
    ovf_m        = 1'b0;
    unf_m        = 1'b0;
    nrst         = 1'b0;
    flush        = 1'b0;
    write        = 1'b0;
    read         = 1'b0;
    wdata        = '0;

    // Reset values
    step();
    step();
    chk("rst.level", 32'(level), 0);
    chk("rst.rempty", 32'(rempty), 1);
    chk("rst.ralmost_empty", 32'(ralmost_empty), 1);
    chk("rst.wfull", 32'(wfull), 0);
    chk("rst.walmost_full", 32'(walmost_full), 0);
    chk("rst.overflow", 32'(overflow), 0);
    chk("rst.underflow", 32'(underflow), 0);
    nrst = 1'b1;

    // Fill for DEPTH+2 cycles: last two writes dropped
    for (int i = 0; i < DEPTH + 2; i++) cycle("fill", 1'b1, 1'b0, 1'b0);
    chk("fill.level_end", 32'(level), 256);
    chk("fill.wfull_end", 32'(wfull), 1);
    chk("fill.overflow_end", 32'(overflow), 1);

    // Drain for DEPTH+1 cycles: rdata 0..255, then an underflowing pop
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i < DEPTH) chk("drain.seq", 32'(rdata), i);
      cycle("drain", 1'b0, 1'b1, 1'b0);
    end
    chk("drain.level_end", 32'(level), 0);
    chk("drain.underflow_end", 32'(underflow), 1);

    // Flush clears sticky flags
    cycle("flush0", 1'b0, 1'b0, 1'b1);
    chk("flush0.overflow", 32'(overflow), 0);
    chk("flush0.underflow", 32'(underflow), 0);

    // Write into empty: visible right after the edge, popped on the next one
    next_val = 32'hABCDEF;
    cycle("wempty", 1'b1, 1'b0, 1'b0);
    chk("wempty.rdata", 32'(rdata), 32'hABCDEF);
    chk("wempty.rempty", 32'(rempty), 0);
    cycle("wempty_pop", 1'b0, 1'b1, 1'b0);
    chk("wempty_pop.rempty", 32'(rempty), 1);
    next_val = 1000;

    // Sustained write+read at level 1
    cycle("l1_pre", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) cycle("l1", 1'b1, 1'b1, 1'b0);
    chk("l1.level_end", 32'(level), 1);

    // Sustained write+read at level 128
    for (int i = 0; i < 127; i++) cycle("l128_pre", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) cycle("l128", 1'b1, 1'b1, 1'b0);
    chk("l128.level_end", 32'(level), 128);

    // At full: first cycle only the read is accepted, then level holds at 255
    for (int i = 0; i < 128; i++) cycle("l256_pre", 1'b1, 1'b0, 1'b0);
    chk("l256.full", 32'(wfull), 1);
    cycle("l256_first", 1'b1, 1'b1, 1'b0);
    chk("l256_first.level", 32'(level), 255);
    chk("l256_first.overflow", 32'(overflow), 1);
    for (int i = 0; i < 999; i++) cycle("l256", 1'b1, 1'b1, 1'b0);
    chk("l256.level_end", 32'(level), 255);

    // Flush mid-stream at level 100 with write and read both asserted
    cycle("fl_clr", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) cycle("fl_pre", 1'b1, 1'b0, 1'b0);
    chk("fl_pre.level", 32'(level), 100);
    cycle("fl", 1'b1, 1'b1, 1'b1);
    chk("fl.level", 32'(level), 0);
    chk("fl.rempty", 32'(rempty), 1);
    next_val = 32'h123456;
    cycle("fl_post", 1'b1, 1'b0, 1'b0);
    chk("fl_post.rdata", 32'(rdata), 32'h123456);
    chk("fl_post.level", 32'(level), 1);

    // Asynchronous reset between edges at level 50
    cycle("ar_clr", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) cycle("ar_pre", 1'b1, 1'b0, 1'b0);
    chk("ar_pre.level", 32'(level), 50);
    #3;
    nrst = 1'b0;
    #1;
    chk("ar.level", 32'(level), 0);
    chk("ar.rempty", 32'(rempty), 1);
    chk("ar.ralmost_empty", 32'(ralmost_empty), 1);
    chk("ar.wfull", 32'(wfull), 0);
    step();
    nrst = 1'b1;
    model_q.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    next_val = 7;
    for (int i = 0; i < 4; i++) cycle("ar_resume_w", 1'b1, 1'b0, 1'b0);
    chk("ar_resume.head", 32'(rdata), 7);
    for (int i = 0; i < 4; i++) cycle("ar_resume_r", 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
